// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Upper bounds for the channel-extract helper; callers cast in and out.
    localparam int unsigned MaxVecW  = 4096;
    localparam int unsigned MaxChanW = 256;

    function automatic logic [MaxChanW-1:0] get_chan(input logic [MaxVecW-1:0] vec,
                                                     input int unsigned k,
                                                     input int unsigned w);
        logic [MaxVecW-1:0] shifted;
        shifted = vec >> (k * w);
        return shifted[MaxChanW-1:0];
    endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin channel pointer for scan mode; advances by one and wraps N-1 -> 0.
module mux_scan_ptr #(
    parameter  int unsigned N  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          adv_i,
    output logic [SW-1:0] ptr_o
);

    logic [SW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && adv_i) begin
            ptr_d = (ptr_q == SW'(N - 1)) ? '0 : ptr_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mux_n1_stream.sv
// N:1 W-bit stream mux with registered valid/ready output; manual or round-robin scan select.
// Optional per-channel enable port chan_en_i when MUX_CHAN_MASK_EN is defined.
module mux_n1_stream
    import mux_pkg::*;
#(
    parameter  int unsigned N  = 8,
    parameter  int unsigned W  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           mode_i,
    input  logic [SW-1:0]  sel_i,
    input  logic [N*W-1:0] in_data_i,
    input  logic [N-1:0]   in_valid_i,
`ifdef MUX_CHAN_MASK_EN
    input  logic [N-1:0]   chan_en_i,
`endif
    output logic [N-1:0]   in_ready_o,
    output logic [W-1:0]   out_data_o,
    output logic [SW-1:0]  out_ch_o,
    output logic           out_valid_o,
    input  logic           out_ready_i
);

    logic [N-1:0]  eff_valid;
    logic [SW-1:0] ptr, cur;
    logic          cur_ok, cur_valid, slot_free, load, adv;

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;

`ifdef MUX_CHAN_MASK_EN
    assign eff_valid = in_valid_i & chan_en_i;
`else
    assign eff_valid = in_valid_i;
`endif

    assign cur       = (mode_i == MODE_SCAN) ? ptr : sel_i;
    // Only reachable with non-power-of-two N and an out-of-range manual sel.
    assign cur_ok    = 32'(cur) < N;
    assign cur_valid = cur_ok && eff_valid[cur];
    assign slot_free = !out_valid_q || out_ready_i;
    assign load      = !rst_i && slot_free && cur_valid;
    assign adv       = load || !eff_valid[ptr];

    mux_scan_ptr #(
        .N (N)
    ) u_scan_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (mode_i),
        .adv_i (adv),
        .ptr_o (ptr)
    );

    always_comb begin
        in_ready_o = '0;
        if (load) begin
            in_ready_o[cur] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = W'(get_chan(MaxVecW'(in_data_i), 32'(cur), W));
            out_ch_d    = cur;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_n1_stream.sv
// Self-checking bench for mux_n1_stream: cycle model compared every cycle plus literal checks.
module tb_mux_n1_stream;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 3;

    logic           clk = 1'b0;
    logic           rst, mode, out_ready, out_valid;
    logic [SW-1:0]  sel, out_ch;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, chan_en, in_ready;
    logic [W-1:0]   out_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mux_n1_stream #(
        .N (N),
        .W (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .sel_i       (sel),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
`ifdef MUX_CHAN_MASK_EN
        .chan_en_i   (chan_en),
`endif
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending word plus a scan index kept as plain integers.
    int m_ptr   = 0;
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_ch    = 0;

    function automatic bit ev(input int k);
        return in_valid[k] && chan_en[k];
    endfunction

    function automatic int m_cur();
        return mode ? m_ptr : int'(sel);
    endfunction

    function automatic bit m_load();
        int c;
        c = m_cur();
        return !rst && (!m_valid || out_ready) && (c < N) && ev(c);
    endfunction

    always @(posedge clk) begin : model
        bit ld;
        int c;
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_data = 0; m_ch = 0;
        end else begin
            ld = m_load();
            c  = m_cur();
            if (ld) begin
                m_data  = int'(in_data[c*W +: W]);
                m_ch    = c;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (mode && (ld || !ev(m_ptr))) m_ptr = (m_ptr + 1) % N;
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] er;
        if (chk_en) begin
            er = m_load() ? (N'(1) << m_cur()) : '0;
            check("model_in_ready", in_ready, er);
            check("model_out_valid", out_valid, m_valid);
            check("model_out_data", out_data, m_data);
            check("model_out_ch", out_ch, m_ch);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    initial begin : stim
        int got[$];
        int exp4[6];
        int budget;
        exp4 = '{0, 2, 7, 0, 2, 7};

        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
        chan_en = '1; in_data = {$urandom, $urandom};

        // Reset held two cycles with every channel valid
        cyc();
        chk_en = 1'b1;
        repeat (2) begin
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_ch", out_ch, 0);
            check("rst_ready", in_ready, 0);
            cyc();
        end

        // Manual capture of channel 5
        rst = 1'b0; sel = 3'd5; in_valid = 8'h20; set_ch(5, 8'hA5);
        #1 check("man_in_ready", in_ready, 8'h20);
        cyc();
        check("man_valid", out_valid, 1);
        check("man_data", out_data, 8'hA5);
        check("man_ch", out_ch, 5);

        // Backpressure holds the word and blocks capture
        out_ready = 1'b0; set_ch(5, 8'h3C);
        repeat (4) begin
            #1 check("bp_in_ready", in_ready, 0);
            cyc();
            check("bp_hold_data", out_data, 8'hA5);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 8'h20);
        cyc();
        check("bp_new_data", out_data, 8'h3C);
        in_valid = '0;
        cyc();
        check("drain_valid", out_valid, 0);

        // Scan skipping idle channels with wrap
        mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1;
        for (int k = 0; k < N; k++) set_ch(k, 8'(k * 17));
        budget = 0;
        while (got.size() < 6 && budget < 40) begin
            cyc();
            budget++;
            if (out_valid) begin
                got.push_back(int'(out_ch));
                check("scan_data", out_data, out_ch * 17);
            end
        end
        check("scan_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) check("scan_seq", got[i], exp4[i]);

        // Random traffic: toggling ready, then random ready, mode flips, rare resets
        for (int i = 0; i < 400; i++) begin
            in_valid = N'($urandom);
            in_data  = {$urandom, $urandom};
            sel      = SW'($urandom_range(0, N - 1));
            out_ready = (i < 200) ? 1'(i % 2) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            rst = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rst = 1'b0;

        // Reset mid-transfer drops the word and restarts scan at 0
        mode = 1'b1; in_valid = '1; out_ready = 1'b0;
        cyc();
        cyc();
        check("mid_pre_valid", out_valid, 1);
        rst = 1'b1;
        cyc();
        check("mid_rst_valid", out_valid, 0);
        rst = 1'b0; out_ready = 1'b1;
        cyc();
        check("mid_restart_ch0", out_ch, 0);
        check("mid_restart_valid", out_valid, 1);
        cyc();
        check("mid_restart_ch1", out_ch, 1);

`ifdef MUX_CHAN_MASK_EN
        // Masked channel 2 never appears in either mode
        chan_en = 8'hFB; in_valid = '1; mode = 1'b1; out_ready = 1'b1;
        repeat (30) begin
            cyc();
            if (out_valid) check("mask_no_ch2", out_ch == 3'd2, 0);
        end
        mode = 1'b0; sel = 3'd2;
        cyc();
        repeat (5) begin
            cyc();
            check("mask_manual_valid", out_valid, 0);
        end
        chan_en = '1;
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
